// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the 5-stage MIPS core.
// Owns the PC, drives a req/ack fetch port, skids one word under stall and drops stale fetches after a flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    state_t      state, state_n;
    if_id_t      ifid, ifid_n, bubble;
    logic [31:0] pc, pc_n, tgt, tgt_n;
    logic [31:0] sk_instr, sk_instr_n, sk_pc4, sk_pc4_n;
    logic [31:0] pc_inc, rd_pc;

    assign pc_inc = pc + 32'd4;
    assign rd_pc  = redirect_pc & ~32'h3;
    assign bubble = '{instr: 32'h0, pc4: ifid.pc4, valid: 1'b0};

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        tgt_n      = tgt;
        sk_instr_n = sk_instr;
        sk_pc4_n   = sk_pc4;
        ifid_n     = ifid;
        case (state)
            FETCH: begin
                if (flush) begin
                    ifid_n = bubble;
                    if (imem_ack) begin
                        pc_n = rd_pc;
                    end else begin
                        tgt_n   = rd_pc;
                        state_n = DISCARD;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_inc;
                    if (stall) begin
                        sk_instr_n = imem_rdata;
                        sk_pc4_n   = pc_inc;
                        state_n    = HOLD;
                    end else begin
                        ifid_n = '{instr: imem_rdata, pc4: pc_inc, valid: 1'b1};
                    end
                end else if (!stall) begin
                    ifid_n = bubble;
                end
            end
            HOLD: begin
                if (flush) begin
                    ifid_n  = bubble;
                    pc_n    = rd_pc;
                    state_n = FETCH;
                end else if (!stall) begin
                    ifid_n  = '{instr: sk_instr, pc4: sk_pc4, valid: 1'b1};
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                // The stale request must complete before the redirect can be issued.
                ifid_n = bubble;
                if (imem_ack) begin
                    pc_n    = flush ? rd_pc : tgt;
                    state_n = FETCH;
                end else if (flush) begin
                    tgt_n = rd_pc;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            tgt      <= 32'h0;
            sk_instr <= 32'h0;
            sk_pc4   <= 32'h0;
            ifid     <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            tgt      <= tgt_n;
            sk_instr <= sk_instr_n;
            sk_pc4   <= sk_pc4_n;
            ifid     <= ifid_n;
        end
    end

    assign imem_req    = (state != HOLD) && !rst;
    assign imem_addr   = pc;
    assign fetch_busy  = !rst && (((state == FETCH) && !imem_ack) || (state == DISCARD));
    assign if_id_instr = ifid.instr;
    assign if_id_pc4   = ifid.pc4;
    assign if_id_valid = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked against a program-order model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, fetch_busy;

    logic        w_req, w_valid, w_busy;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc4;

    logic force_ack = 1'b1, rand_lat = 1'b0;
    int   lat_fixed = 0, lat_r = 0, cnt = 0, cur_lat;
    int   total = 0, passed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    // Memory: acks after cur_lat waiting cycles, or every cycle when force_ack.
    assign cur_lat    = rand_lat ? lat_r : lat_fixed;
    assign imem_ack   = force_ack || (imem_req && cnt >= cur_lat);
    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (imem_req && imem_ack) begin
            cnt   <= 0;
            lat_r <= $urandom_range(0, 3);
        end else if (imem_req) cnt <= cnt + 1;
    end

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_busy(fetch_busy)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata), .imem_ack(1'b1),
        .if_id_instr(w_instr), .if_id_pc4(w_pc4), .if_id_valid(w_valid), .fetch_busy(w_busy)
    );

    task automatic test_reset_stream();
        logic [64:0] exp;
        repeat (2) @(negedge clk);
        total++;
        if ({imem_req, fetch_busy, if_id_valid, if_id_instr, if_id_pc4, imem_addr} !== 100'h0)
            $display("FAIL reset_state: got req=%b busy=%b v=%b i=%h p=%h a=%h want all 0",
                     imem_req, fetch_busy, if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, w_addr} !== {1'b1, 32'h0, 32'hFFFF_FFFC})
            $display("FAIL first_req: got req=%b a=%h wa=%h want 1 0 fffffffc", imem_req, imem_addr, w_addr);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 32'h100 + 32'(k), 32'(4 * (k + 1))};
            total++;
            if ({if_id_valid, if_id_instr, if_id_pc4} !== exp)
                $display("FAIL stream%0d: got %h want %h", k, {if_id_valid, if_id_instr, if_id_pc4}, exp);
            else passed++;
            if (k == 0) begin
                total++;
                if ({w_valid, w_instr, w_pc4, w_addr} !== {1'b1, 32'h4000_00FF, 32'h0, 32'h0})
                    $display("FAIL pc_wrap: got v=%b i=%h p=%h a=%h want 1 400000ff 0 0",
                             w_valid, w_instr, w_pc4, w_addr);
                else passed++;
            end
        end
    endtask

    task automatic test_stall();
        int          fetches = 0;
        logic [31:0] fa = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4, imem_addr} !== {1'b1, 32'h104, 32'h14, 32'h14})
            $display("FAIL stall_pre: got %h %h %h want 104 14 14", if_id_instr, if_id_pc4, imem_addr);
        else passed++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (imem_req && imem_ack) begin fetches++; fa = imem_addr; end
            @(negedge clk);
            total++;
            if ({if_id_valid, if_id_instr} !== {1'b1, 32'h104})
                $display("FAIL stall_hold%0d: got %h want 104", k, if_id_instr);
            else passed++;
        end
        stall = 1'b0;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'h105, 32'h18})
            $display("FAIL stall_next: got %h/%h want 105/18", if_id_instr, if_id_pc4);
        else passed++;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'h106, 32'h1C})
            $display("FAIL stall_next2: got %h/%h want 106/1c", if_id_instr, if_id_pc4);
        else passed++;
        total++;
        if (fetches != 1 || fa !== 32'h14)
            $display("FAIL stall_fetches: got %0d at %h want 1 at 14", fetches, fa);
        else passed++;
    endtask

    task automatic test_flush_zero();
        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4, imem_addr} !== {1'b0, 32'h0, 32'h1C, 32'h40})
            $display("FAIL flush_bubble: got v=%b i=%h p=%h a=%h want 0 0 1c 40",
                     if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        else passed++;
        flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'h110, 32'h44})
            $display("FAIL flush_target: got %h/%h want 110/44", if_id_instr, if_id_pc4);
        else passed++;
    endtask

    task automatic wait_addr_change(input logic [31:0] old, input logic [31:0] want, input string nm);
        bit stale = 0;
        int k = 0;
        while (imem_addr === old && k < 12) begin
            @(negedge clk);
            if (if_id_valid) stale = 1;
            k++;
        end
        total++;
        if (imem_addr !== want || stale)
            $display("FAIL %s: got a=%h stale=%0d want a=%h stale=0", nm, imem_addr, stale, want);
        else passed++;
    endtask

    task automatic wait_valid(input logic [64:0] exp, input string nm);
        int k = 0;
        while (!if_id_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== exp)
            $display("FAIL %s: got %h want %h", nm, {if_id_valid, if_id_instr, if_id_pc4}, exp);
        else passed++;
    endtask

    task automatic test_flush_wait();
        force_ack = 1'b0; lat_fixed = 3;
        #1;
        total++;
        if (fetch_busy !== 1'b1) $display("FAIL busy_wait: got %b want 1", fetch_busy);
        else passed++;
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if ({imem_addr, fetch_busy, if_id_valid} !== {32'h44, 1'b1, 1'b0})
            $display("FAIL discard_hold: got a=%h busy=%b v=%b want 44 1 0", imem_addr, fetch_busy, if_id_valid);
        else passed++;
        wait_addr_change(32'h44, 32'h80, "flush_wait_addr");
        wait_valid({1'b1, 32'h120, 32'h84}, "flush_wait_data");
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'hA0;
        @(negedge clk);
        redirect_pc = 32'hC0;
        @(negedge clk);
        flush = 1'b0;
        wait_addr_change(32'h84, 32'hC0, "second_flush_addr");
        wait_valid({1'b1, 32'h130, 32'hC4}, "second_flush_data");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        flush = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({imem_req, fetch_busy, if_id_valid, if_id_instr, if_id_pc4, imem_addr} !== 100'h0)
            $display("FAIL async_reset: got req=%b busy=%b v=%b i=%h p=%h a=%h want all 0",
                     imem_req, fetch_busy, if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        else passed++;
        @(negedge clk);
        rst = 1'b0; force_ack = 1'b1;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL post_reset_req: got req=%b a=%h want 1 0", imem_req, imem_addr);
        else passed++;
        @(negedge clk);
        total++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'h100, 32'h4})
            $display("FAIL post_reset_data: got %h/%h want 100/4", if_id_instr, if_id_pc4);
        else passed++;
    endtask

    // Program-order model: deliveries follow sequential PCs, restarting at the latest redirect.
    task automatic test_random();
        logic [64:0] prev = '0, cur, exp;
        logic [31:0] exp_pc = 32'h0, p_addr, p_rd = 32'h0;
        logic        p_req, p_ack, p_stall = 1'b0, p_flush = 1'b0;
        int          deliveries = 0;
        @(negedge clk);
        rst = 1'b1; force_ack = 1'b0; rand_lat = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cur = {if_id_valid, if_id_instr, if_id_pc4};
            if (p_flush) begin
                exp = {1'b0, 32'h0, prev[31:0]};
                exp_pc = p_rd & ~32'h3;
            end else if (p_stall) begin
                exp = prev;
            end else if (if_id_valid) begin
                exp = {1'b1, mem_word(exp_pc), exp_pc + 32'd4};
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end else begin
                exp = {1'b0, 32'h0, prev[31:0]};
            end
            total++;
            if (cur !== exp) $display("FAIL rand_ifid c=%0d: got %h want %h", c, cur, exp);
            else passed++;
            if (p_req && !p_ack) begin
                total++;
                if (imem_addr !== p_addr) $display("FAIL rand_addr_stable c=%0d: got %h want %h", c, imem_addr, p_addr);
                else passed++;
            end
            prev = cur;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
            #1;
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_stall = stall; p_flush = flush; p_rd = redirect_pc;
        end
        stall = 1'b0; flush = 1'b0;
        total++;
        if (deliveries < 30) $display("FAIL rand_progress: got %0d deliveries want >=30", deliveries);
        else passed++;
    endtask

    initial begin
        test_reset_stream();
        test_stall();
        test_flush_zero();
        test_flush_wait();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. The block owns the PC, issues word requests to instruction memory over a req/ack handshake, and delivers fetched instructions into the IF/ID register. It consumes the hazard unit's `stall` (load-use hold) and `flush` (taken branch/jump) outputs, together with the EX-stage redirect target. Because memory may take several cycles, the block buffers one instruction under stall and discards an in-flight fetch after a flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold the PC and IF/ID register (load-use hazard).
- `flush`  in  1: squash IF/ID and redirect fetch to `redirect_pc`. Takes priority over `stall`.
- `redirect_pc`  in  32: branch/jump target. Sampled only when `flush`=1.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_rdata`  in  32: instruction word. Valid when `imem_ack`=1.
- `imem_ack`  in  1: memory response. May arrive in the same cycle as the request; tying it high gives zero-wait memory.
- `if_id_instr`  out  32: IF/ID instruction.
- `if_id_pc4`  out  32: IF/ID PC+4 of that instruction.
- `if_id_valid`  out  1: IF/ID holds a real instruction. 0 marks a bubble.
- `fetch_busy`  out  1: high in FETCH while the request is not yet acked, or in DISCARD.

## Operation

Internal state:
- `pc`.
- Skid buffer: `sk_instr`, `sk_pc4`.
- Saved target `tgt`.
- State machine with states FETCH, HOLD, DISCARD.

`imem_addr` is `pc` in every state. `imem_req` = (state != HOLD) and not `rst`. `imem_addr` is stable while `imem_req`=1 and no ack has arrived.

A "bubble" means the IF/ID register is loaded with `if_id_valid`=0 and `if_id_instr`=0; `if_id_pc4` keeps its value.

FETCH:
- `flush` and `imem_ack`: drop `imem_rdata`; `pc`<=`redirect_pc`; load a bubble; stay in FETCH.
- `flush`, no ack: `tgt`<=`redirect_pc`; load a bubble; go to DISCARD.
- Ack, not stalled: IF/ID<={`imem_rdata`, `pc`+4, valid=1}; `pc`<=`pc`+4.
- Ack, stalled: skid<={`imem_rdata`, `pc`+4}; `pc`<=`pc`+4; IF/ID held; go to HOLD.
- No ack, not stalled: load a bubble.
- No ack, stalled: IF/ID held.

HOLD (no request outstanding):
- `flush`: load a bubble; `pc`<=`redirect_pc`; skid contents discarded; go to FETCH.
- Not stalled: IF/ID<={`sk_instr`, `sk_pc4`, valid=1}; go to FETCH.
- Stalled: stay in HOLD; everything held.

DISCARD (the stale request is still outstanding at the old `pc`):
- `flush` with no ack: `tgt`<=`redirect_pc` (latest flush wins).
- `imem_ack`: data dropped; `pc`<=(`flush` ? `redirect_pc` : `tgt`); go to FETCH.
- IF/ID is a bubble throughout; `stall` is ignored.

Arithmetic:
- `pc`+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- `redirect_pc[1:0]` is ignored; the block forces it to 2'b00.

Reset, asserted at any time including mid-request:
- `pc`=`RESET_PC`, state=FETCH.
- `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0.
- Skid and `tgt` = 0; `imem_req`=0; `fetch_busy`=0.
- An ack arriving during reset is ignored.
- After release, the first request goes to `RESET_PC`.

## Timing
- Zero-wait memory (`imem_ack`=1 always): one instruction per cycle. The instruction at address A is on IF/ID in the cycle after A appears on `imem_addr`.
- N-cycle memory: the IF/ID update happens at the edge where `imem_ack`=1. Bubbles are inserted in the preceding cycles unless stalled.
- Flush with zero-wait memory: `redirect_pc` appears on `imem_addr` in the cycle after `flush`. Exactly one bubble is inserted.
- Flush during an outstanding request: the redirect address is issued in the cycle after the stale ack.
- Stall of k cycles with zero-wait memory: no instruction is lost or duplicated. Exactly one memory fetch occurs during the stall.
- No combinational path from `stall`, `flush` or `imem_ack` to `imem_req` or `imem_addr`.

## Test plan
- Reset and streaming: `RESET_PC`=0, `imem_ack`=1, memory[i]=i+0x100. Required: `if_id_instr` sequence 0x100, 0x101, 0x102 with `if_id_pc4`=4, 8, 12 and `if_id_valid`=1 from the second cycle after reset release.
- Load-use stall: assert `stall` for 2 cycles while word 0x104 is on IF/ID. Required: IF/ID holds 0x104 for 3 cycles, then 0x105 and 0x106 follow with none skipped or duplicated, and exactly one fetch at address 0x14 during the stall.
- Flush with zero-wait memory: assert `flush` with `redirect_pc`=0x40 (plus a concurrent `stall`). Required: next IF/ID is a bubble, `imem_addr`=0x40 in the following cycle, then IF/ID holds memory[0x40].
- Flush during a 3-cycle memory wait: `flush`, `redirect_pc`=0x80, issued one cycle into the request. Required: `imem_addr` held until the ack, stale data never reaches IF/ID, then `imem_addr`=0x80; a second flush to 0xC0 before the ack makes 0xC0 the issued address instead.
- Async reset mid-request: assert `rst` between edges while in DISCARD. Required: outputs reset immediately, and the first request after release is to `RESET_PC`.
- PC wrap: `RESET_PC`=32'hFFFF_FFFC. Required: the next fetch address is 0, and `if_id_pc4` for the first instruction is 0.
